fir_sample_driver: RTL and testbench

Initiator-side sequencer for the FIR datapath's start/halt sample interface.
- Holds a small software-loaded sample buffer.
- On a go request, issues the start pulse, streams the 4-bit samples, asserts halt, then waits for the filter's done.
- Captures the filter result and reports it, with a watchdog timeout so a hung filter never stalls the driver.

---
 rtl/fir_sample_driver.sv | 124 ++++++++++++
 tb/tb_fir_sample_driver.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fir_sample_driver.sv
// rtl/fir_sample_driver.sv - sequencer that streams a loaded sample buffer into the FIR start/halt interface
// and captures the result, with a watchdog on the filter's done strobe.
module fir_sample_driver #(
  parameter int DEPTH   = 16,
  parameter int TIMEOUT = 64
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       wr_en,
  input  logic [3:0] wr_addr,
  input  logic [3:0] wr_data,
  input  logic [4:0] len,
  input  logic       go,
  output logic       busy,
  output logic       fir_start,
  output logic [3:0] fir_in,
  output logic       fir_halt,
  input  logic       fir_done,
  input  logic [8:0] fir_y,
  output logic [8:0] result,
  output logic       result_valid,
  output logic       timeout_err
);

  localparam int             WDW       = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [WDW-1:0] WD_LAST   = WDW'(TIMEOUT - 1);
  localparam logic [3:0]     IDX_MASK  = 4'(DEPTH - 1);
  localparam logic [4:0]     DEPTH_LEN = 5'(DEPTH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_STREAM,
    S_HALT,
    S_WAIT,
    S_DONE
  } state_t;

  state_t         state;
  logic [3:0]     sample_buf [16];
  logic [3:0]     idx;
  logic [4:0]     remaining;
  logic [WDW-1:0] wd;

  // Buffer is software-loaded and deliberately not reset.
  always_ff @(posedge clk) begin
    if (wr_en && state == S_IDLE) begin
      sample_buf[wr_addr & IDX_MASK] <= wr_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= S_IDLE;
      busy         <= 1'b0;
      fir_start    <= 1'b0;
      fir_in       <= 4'd0;
      fir_halt     <= 1'b0;
      result       <= 9'd0;
      result_valid <= 1'b0;
      timeout_err  <= 1'b0;
      idx          <= 4'd0;
      remaining    <= 5'd0;
      wd           <= '0;
    end else begin
      fir_start    <= 1'b0;
      fir_halt     <= 1'b0;
      fir_in       <= 4'd0;
      result_valid <= 1'b0;
      case (state)
        S_IDLE: begin
          if (go && len != 5'd0) begin
            state       <= S_START;
            busy        <= 1'b1;
            timeout_err <= 1'b0;
            fir_start   <= 1'b1;
            idx         <= 4'd0;
            remaining   <= (len > DEPTH_LEN) ? DEPTH_LEN : len;
          end
        end
        S_START: begin
          fir_in    <= sample_buf[idx];
          idx       <= (idx + 4'd1) & IDX_MASK;
          remaining <= remaining - 5'd1;
          state     <= S_STREAM;
        end
        S_STREAM: begin
          // remaining counts samples not yet presented; zero means the last one is on fir_in now.
          if (remaining == 5'd0) begin
            fir_halt <= 1'b1;
            state    <= S_HALT;
          end else begin
            fir_in    <= sample_buf[idx];
            idx       <= (idx + 4'd1) & IDX_MASK;
            remaining <= remaining - 5'd1;
          end
        end
        S_HALT: begin
          wd    <= '0;
          state <= S_WAIT;
        end
        S_WAIT: begin
          if (fir_done) begin
            result       <= fir_y;
            result_valid <= 1'b1;
            state        <= S_DONE;
          end else if (wd == WD_LAST) begin
            timeout_err <= 1'b1;
            busy        <= 1'b0;
            state       <= S_IDLE;
          end else begin
            wd <= wd + 1'b1;
          end
        end
        S_DONE: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fir_sample_driver.sv
// tb/tb_fir_sample_driver.sv - scoreboard bench for fir_sample_driver.
module tb_fir_sample_driver;

  localparam int TIMEOUT = 64;

  logic       clk = 1'b0;
  logic       rst;
  logic       wr_en;
  logic [3:0] wr_addr;
  logic [3:0] wr_data;
  logic [4:0] len;
  logic       go;
  logic       busy;
  logic       fir_start;
  logic [3:0] fir_in;
  logic       fir_halt;
  logic       fir_done;
  logic [8:0] fir_y;
  logic [8:0] result;
  logic       result_valid;
  logic       timeout_err;

  int total = 0;
  int bad   = 0;

  logic [3:0] model [16];
  logic [3:0] exp_samples [$];
  logic [8:0] exp_results [$];
  logic [8:0] last_result;
  bit         in_stream;

  fir_sample_driver #(.DEPTH(16), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .len(len), .go(go), .busy(busy), .fir_start(fir_start), .fir_in(fir_in),
    .fir_halt(fir_halt), .fir_done(fir_done), .fir_y(fir_y), .result(result),
    .result_valid(result_valid), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  task automatic monitor();
    logic [3:0] e;
    logic [8:0] ey;
    total++;
    if ((fir_start & fir_halt) !== 1'b0) begin
      bad++; $display("FAIL start_halt_overlap got=1 expected=0");
    end
    if (in_stream && !fir_halt) begin
      total++;
      if (exp_samples.size() == 0) begin
        bad++; $display("FAIL extra_sample got=%0d expected=none", fir_in);
      end else begin
        e = exp_samples.pop_front();
        if (fir_in !== e) begin bad++; $display("FAIL sample got=%0d expected=%0d", fir_in, e); end
      end
    end else begin
      total++;
      if (fir_in !== 4'd0) begin bad++; $display("FAIL idle_fir_in got=%0d expected=0", fir_in); end
    end
    if (fir_halt) begin
      in_stream = 1'b0;
      total++;
      if (exp_samples.size() != 0) begin
        bad++; $display("FAIL short_stream left=%0d expected=0", exp_samples.size());
      end
    end
    if (fir_start) in_stream = 1'b1;
    if (result_valid) begin
      total++;
      if (exp_results.size() == 0) begin
        bad++; $display("FAIL unexpected_result_valid got=1 expected=0");
      end else begin
        ey = exp_results.pop_front();
        if (result !== ey) begin bad++; $display("FAIL result got=%h expected=%h", result, ey); end
        last_result = ey;
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
    monitor();
  endtask

  task automatic write_buf(input int a, input logic [3:0] d);
    wr_en = 1'b1; wr_addr = 4'(a); wr_data = d;
    step();
    wr_en = 1'b0;
    model[a] = d;
  endtask

  task automatic do_run(input int ln, input int done_w, input logic [8:0] y, input bit poke);
    int l, cyc, wait0;
    bit fin;
    l = (ln > 16) ? 16 : ln;
    for (int k = 0; k < l; k++) exp_samples.push_back(model[k]);
    if (done_w >= 0) exp_results.push_back(y);
    wait0 = l + 3;
    len = 5'(ln); go = 1'b1;
    step();
    go = 1'b0;
    total++;
    if (fir_start !== 1'b1 || busy !== 1'b1 || timeout_err !== 1'b0) begin
      bad++; $display("FAIL run_start start=%b busy=%b terr=%b expected=1 1 0", fir_start, busy, timeout_err);
    end
    fin = 1'b0;
    cyc = 1;
    while (cyc < wait0 + TIMEOUT + 5 && !fin) begin
      fir_done = (done_w >= 0 && cyc == wait0 + done_w);
      fir_y    = fir_done ? y : 9'($urandom);
      go = 1'b0; wr_en = 1'b0;
      if (poke && cyc == 3) begin
        go = 1'b1; wr_en = 1'b1; wr_addr = 4'd0; wr_data = ~model[0];
      end else if (poke && done_w >= 0 && cyc == wait0 + done_w + 1) begin
        go = 1'b1;
      end
      step();
      cyc++;
      if (cyc == l + 2) begin
        total++;
        if (fir_halt !== 1'b1) begin bad++; $display("FAIL halt_cycle got=%b expected=1 cyc=%0d", fir_halt, cyc); end
      end
      if (done_w >= 0 && cyc == wait0 + done_w + 1) begin
        total++;
        if (result_valid !== 1'b1) begin bad++; $display("FAIL result_valid_cycle got=%b expected=1", result_valid); end
      end
      if (done_w >= 0 && cyc == wait0 + done_w + 2) begin
        total++;
        if (busy !== 1'b0 || timeout_err !== 1'b0) begin
          bad++; $display("FAIL run_end busy=%b terr=%b expected=0 0", busy, timeout_err);
        end
        fin = 1'b1;
      end
      if (done_w < 0 && cyc == wait0 + TIMEOUT - 1) begin
        total++;
        if (timeout_err !== 1'b0 || busy !== 1'b1) begin
          bad++; $display("FAIL early_timeout terr=%b busy=%b expected=0 1", timeout_err, busy);
        end
      end
      if (done_w < 0 && cyc == wait0 + TIMEOUT) begin
        total++;
        if (timeout_err !== 1'b1 || busy !== 1'b0 || result !== last_result) begin
          bad++; $display("FAIL timeout terr=%b busy=%b result=%h expected=1 0 %h", timeout_err, busy, result, last_result);
        end
        fin = 1'b1;
      end
    end
    fir_done = 1'b0; go = 1'b0; wr_en = 1'b0;
    if (!fin) begin bad++; total++; $display("FAIL run_budget got=expired expected=finish"); end
  endtask

  task automatic test_reset();
    rst = 1'b1; wr_en = 1'b0; wr_addr = 4'd0; wr_data = 4'd0; len = 5'd0; go = 1'b0;
    fir_done = 1'b0; fir_y = 9'd0; in_stream = 1'b0; last_result = 9'd0;
    #1;
    total++;
    if ({busy, fir_start, fir_in, fir_halt, result, result_valid, timeout_err} !== 18'd0) begin
      bad++; $display("FAIL reset_outputs got=%h expected=0", {busy, fir_start, fir_in, fir_halt, result, result_valid, timeout_err});
    end
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_basic();
    write_buf(0, 4'd1); write_buf(1, 4'd2); write_buf(2, 4'd3); write_buf(3, 4'd4);
    for (int a = 4; a < 16; a++) write_buf(a, 4'($urandom));
    do_run(4, 3, 9'h0A5, 1'b0);
  endtask

  task automatic test_len_bounds();
    len = 5'd0; go = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      total++;
      if (busy !== 1'b0 || fir_start !== 1'b0) begin
        bad++; $display("FAIL len_zero busy=%b start=%b expected=0 0", busy, fir_start);
      end
    end
    go = 1'b0;
    do_run(20, 0, 9'h155, 1'b0);
  endtask

  task automatic test_timeout();
    do_run(2, -1, 9'h000, 1'b0);
    do_run(1, 5, 9'h1C3, 1'b0);
  endtask

  task automatic test_race();
    do_run(3, TIMEOUT - 1, 9'h07E, 1'b0);
  endtask

  task automatic test_ignored_inputs();
    do_run(4, 2, 9'h123, 1'b1);
    for (int i = 0; i < 3; i++) begin
      step();
      total++;
      if (busy !== 1'b0) begin bad++; $display("FAIL go_in_done busy=%b expected=0", busy); end
    end
    do_run(4, 1, 9'h0F0, 1'b0);
  endtask

  task automatic test_reset_mid();
    exp_samples.push_back(model[0]); exp_samples.push_back(model[1]);
    len = 5'd4; go = 1'b1;
    step();
    go = 1'b0;
    step(); step();
    #2 rst = 1'b1;
    #1;
    total++;
    if ({busy, fir_start, fir_in, fir_halt, result, result_valid, timeout_err} !== 18'd0) begin
      bad++; $display("FAIL reset_mid got=%h expected=0", {busy, fir_start, fir_in, fir_halt, result, result_valid, timeout_err});
    end
    @(negedge clk);
    rst = 1'b0;
    exp_samples.delete(); exp_results.delete();
    in_stream = 1'b0; last_result = 9'd0;
    do_run(4, 1, 9'h1AA, 1'b0);
  endtask

  task automatic test_back_to_back();
    int starts, rvs, rv_cyc, cyc;
    starts = 0; rvs = 0; rv_cyc = -1;
    len = 5'd2; go = 1'b1; fir_done = 1'b1; fir_y = 9'h03C;
    for (cyc = 0; cyc < 60 && !(rvs == 3 && busy == 1'b0); cyc++) begin
      if (starts < 3 || rvs < 3) exp_results.push_back(9'h03C);
      step();
      void'(exp_results.pop_back());
      if (fir_start) begin
        starts++;
        exp_samples.push_back(model[0]); exp_samples.push_back(model[1]);
        if (rv_cyc >= 0) begin
          total++;
          if (cyc - rv_cyc < 2) begin bad++; $display("FAIL b2b_gap got=%0d expected>=2", cyc - rv_cyc); end
        end
      end
      if (result_valid) begin
        rvs++; rv_cyc = cyc;
        if (rvs == 3) go = 1'b0;
      end
    end
    fir_done = 1'b0;
    for (int i = 0; i < 4; i++) step();
    total++;
    if (starts != 3 || rvs != 3 || busy !== 1'b0) begin
      bad++; $display("FAIL b2b_runs starts=%0d pulses=%0d busy=%b expected=3 3 0", starts, rvs, busy);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_len_bounds();
    test_timeout();
    test_race();
    test_ignored_inputs();
    test_reset_mid();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
